uart_transmitter: RTL and testbench



---
 rtl/uart_transmitter.sv | 196 +++++++++++++++++++
 tb/tb_uart_transmitter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART transmitter with a ready/valid byte input and a
// one-entry holding register, so back-to-back bytes leave with no idle gap.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity symbol
// between the data bits and the stop bit (11-symbol frames instead of 10).
//
// state   | meaning
// IDLE    | line high, waiting for a byte
// START   | start bit, line low
// DATA    | 8 data bits, LSB first, bit counter 0-7
// PARITY  | even parity bit (only with UART_TX_PARITY_EN)
// STOP    | stop bit, line high
module uart_transmitter #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out,
    output logic       tx_busy
);

    localparam int FPGA_OFFSET      = 5;
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE - FPGA_OFFSET;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic             rst_meta_q, rst_sync_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             ready_q, ready_d;
    logic             line_q, line_d;
    logic             busy_q, busy_d;
    logic             sym_edge;
    logic             accept;
    logic             direct;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign sym_edge      = (cnt_q == CNT_LAST);
    assign accept        = data_in_valid && ready_q;
    assign data_in_ready = ready_q;
    assign serial_out    = line_q;
    assign tx_busy       = busy_q;

    // Two-flop release synchroniser; assertion still acts asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // Next-state, symbol timer, shift/hold register and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        direct      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        if (rst_sync_q) begin
            if (state_q != S_IDLE) begin
                cnt_d = sym_edge ? '0 : cnt_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        direct  = 1'b1;
                        shift_d = data_in;
                        state_d = S_START;
                        cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^data_in;
`endif
                    end
                end
                S_START: begin
                    if (sym_edge) begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                    end
                end
                S_DATA: begin
                    if (sym_edge) begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (sym_edge) state_d = S_STOP;
                end
`endif
                S_STOP: begin
                    if (sym_edge) begin
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            state_d     = S_START;
`ifdef UART_TX_PARITY_EN
                            parity_d    = ^hold_q;
`endif
                        end else if (accept) begin
                            // A byte arriving on the final edge goes straight out.
                            direct  = 1'b1;
                            shift_d = data_in;
                            state_d = S_START;
`ifdef UART_TX_PARITY_EN
                            parity_d = ^data_in;
`endif
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (accept && !direct) begin
                hold_d      = data_in;
                hold_full_d = 1'b1;
            end
        end
        ready_d = !hold_full_d;
        busy_d  = (state_q != S_IDLE);
        case (state_q)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: line_d = parity_q;
`endif
            default:  line_d = 1'b1;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            line_q      <= 1'b1;
            busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            line_q      <= line_d;
            busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: accepted bytes are queued, a line
// monitor decodes every frame cycle by cycle and compares against the queue.
module tb_uart_transmitter;

    localparam int CLOCK_FREQ = 2100;
    localparam int BAUD_RATE  = 100;
    localparam int SET        = 16;   // 2100/100 - 5
`ifdef UART_TX_PARITY_EN
    localparam int NSYM = 11;
`else
    localparam int NSYM = 10;
`endif
    localparam int FRAME = NSYM * SET;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;
    logic       tx_busy;

    uart_transmitter #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .tx_busy       (tx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         frames   = 0;
    bit         mon_busy = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int sym);
        if (sym == 0) return 1'b0;
        if (sym <= 8) return b[sym-1];
`ifdef UART_TX_PARITY_EN
        if (sym == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Line monitor: one scoreboard comparison per complete frame.
    initial begin : monitor
        int         st;
        int         errs;
        bit         aborted;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n && serial_out == 1'b0) begin
                st       = cyc;
                mon_busy = 1'b1;
                check("frame_expected", int'(exp_q.size() != 0), 1);
                b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                errs    = 0;
                aborted = 1'b0;
                for (int k = 0; k < FRAME; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (serial_out !== frame_bit(b, k / SET) || tx_busy !== 1'b1) errs++;
                end
                if (!aborted) begin
                    frames++;
                    start_q.push_back(st);
                    check($sformatf("frame_%02h_bits", b), errs, 0);
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b, output int acc);
        @(negedge clk);
        data_in       = b;
        data_in_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (data_in_ready) begin
                acc = cyc + 1;
                @(posedge clk);
                exp_q.push_back(b);
                break;
            end
            @(negedge clk);
        end
        check($sformatf("accept_%02h", b), int'(acc >= 0), 1);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        data_in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mon_busy) break;
        end
        check(name, int'(exp_q.size() == 0 && !mon_busy), 1);
    endtask

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a1, a2, a3, s, f0, gaps;
        repeat (3) @(negedge clk);
        check("rst_serial_out", int'(serial_out), 1);
        check("rst_ready", int'(data_in_ready), 1);
        check("rst_busy", int'(tx_busy), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // single byte: latency, exact bit timing, busy drop after stop
        start_q.delete();
        send(8'h55, a1);
        drop_valid();
        drain("drain_55", 2 * FRAME);
        s = (start_q.size() != 0) ? start_q[0] : 0;
        check("latency_55", s - a1, 1);
        while (cyc < s + FRAME) @(negedge clk);
        check("busy_after_frame", int'(tx_busy), 0);
        check("line_after_frame", int'(serial_out), 1);

        // back-to-back with valid held high
        start_q.delete();
        send(8'hA5, a1);
        send(8'h3C, a2);
        drop_valid();
        drain("drain_a5_3c", 3 * FRAME);
        check("second_accept_delay", a2 - a1, 1);
        check("start_spacing", (start_q.size() == 2) ? start_q[1] - start_q[0] : -1, FRAME);

        // backpressure
        start_q.delete();
        send(8'h01, a1);
        send(8'h02, a2);
        #1;
        check("ready_low_when_held", int'(data_in_ready), 0);
        send(8'h03, a3);
        drop_valid();
        drain("drain_010203", 4 * FRAME);
        check("third_accept_time", a3 - a1, FRAME + 1);

        // parity-relevant directed byte
        send(8'h07, a1);
        drop_valid();
        drain("drain_07", 2 * FRAME);

        // reset in the middle of a frame with a byte held
        send(8'h81, a1);
        send(8'h7E, a2);
        drop_valid();
        while (cyc < a1 + 3 * SET + 5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_serial_out", int'(serial_out), 1);
        check("midrst_ready", int'(data_in_ready), 1);
        check("midrst_busy", int'(tx_busy), 0);
        exp_q.delete();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        f0 = frames;
        repeat (3 * FRAME) @(negedge clk);
        check("no_frame_after_reset", frames, f0);
        check("idle_line_after_reset", int'(serial_out), 1);

        // streamed bytes 0x00..0xFF
        start_q.delete();
        f0 = frames;
        for (int b = 0; b < 256; b++) send(8'(b), a1);
        drop_valid();
        drain("drain_stream", 3 * FRAME);
        check("stream_frame_count", frames - f0, 256);
        gaps = 0;
        for (int i = 1; i < start_q.size(); i++)
            if (start_q[i] - start_q[i-1] != FRAME) gaps++;
        check("stream_spacing", gaps, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
